mmio_router: RTL
================

MMIO_ROUTER -- requirements
Module: mmio_router

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of peripheral channels, 1..8.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter DW, default 32: data width.
REQ-004 SHALL have parameter BASE, default {0x0000_0000, 0x0000_0100, 0x0000_0200, 0x0000_0300}, flat N_CH*AW: per-channel base address.
REQ-005 SHALL have parameter MASK, default 0xFFFF_FF00 per channel, flat N_CH*AW: per-channel decode mask.
REQ-006 SHALL have parameter TIMEOUT, default 16: maximum ACCESS cycles before abort, >=2.
REQ-007 SHALL have port clk, input, 1: the single clock; all logic rises on posedge clk.
REQ-008 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have port cpu_addr, input, AW: request address.
REQ-010 SHALL have port cpu_wdata, input, DW: write data.
REQ-011 SHALL have port cpu_we, input, 1: write request.
REQ-012 SHALL have port cpu_re, input, 1: read request.
REQ-013 SHALL have port cpu_rdata, output, DW: registered read data.
REQ-014 SHALL have port cpu_stall, output, 1: CPU must hold its request while high.
REQ-015 SHALL have port periph_addr, output, AW: latched address, shared by all channels.
REQ-016 SHALL have port periph_wdata, output, DW: latched write data, shared by all channels.
REQ-017 SHALL have port periph_we, output, N_CH: one-hot write strobe.
REQ-018 SHALL have port periph_re, output, N_CH: one-hot read strobe.
REQ-019 SHALL have port periph_rdata, input, N_CH*DW: per-channel read data.
REQ-020 SHALL have port periph_ready, input, N_CH: per-channel completion.
REQ-021 SHALL have port err, output, 1: sticky error flag.
REQ-022 SHALL have port err_clear, input, 1: synchronous clear of err.

Function
REQ-023 SHALL decode channel i as hit when (cpu_addr & MASK[i]) == BASE[i]; overlapping hits resolve to the lowest index.
REQ-024 SHALL treat cpu_we and cpu_re both high as a write; the read is ignored.
REQ-025 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-026 SHALL, in IDLE on a mapped request, latch addr, wdata, op and channel, assert cpu_stall combinationally, and go to ACCESS.
REQ-027 SHALL, in IDLE on an unmapped request, assert no strobes, keep cpu_stall low, set err on the next edge, and load cpu_rdata with 0 for reads.
REQ-028 SHALL, in ACCESS, drive exactly one bit of periph_we or periph_re (the latched channel and op), hold cpu_stall high, and increment a wait counter each cycle.
REQ-029 SHALL, on the first ACCESS cycle with periph_ready[ch] high, register periph_rdata[ch] into cpu_rdata (reads only) and go to RESP.
REQ-030 SHALL, when the wait counter reaches TIMEOUT-1 without ready, drop the strobes, set err, load cpu_rdata with 0, and go to RESP.
REQ-031 SHALL, in RESP, drive cpu_stall low and all strobes low for exactly one cycle, then return to IDLE; a request present in RESP is not accepted.
REQ-032 SHALL give minimum transaction latency request -> RESP of 2 cycles when ready is already high on the first ACCESS cycle.
REQ-033 SHALL hold cpu_rdata unchanged on writes and between transactions.
REQ-034 SHALL let a set event win over err_clear in the same cycle.
REQ-035 SHALL ignore periph_ready on non-selected channels.

Reset
REQ-036 SHALL, on reset assertion at any time (including mid-ACCESS), immediately force state IDLE, periph_we = 0, periph_re = 0, cpu_stall = 0, cpu_rdata = 0, periph_addr = 0, periph_wdata = 0, err = 0 and wait counter = 0.
REQ-037 SHALL resume on the first clk edge after reset deasserts.

Structure
REQ-038 SHALL place the state enum, the default TIMEOUT and the default BASE/MASK constants in shared package mmio_pkg.
REQ-039 SHALL implement the combinational priority decoder (hit vector, index, mapped flag) as sub-module mmio_addr_decoder, parametrised by N_CH, AW, BASE and MASK.
REQ-040 SHALL size the wait counter as clog2(TIMEOUT)+1 bits.

Verification
REQ-041 SHALL cover a mapped write: write 0x0000_0104 with data 0xA5A5_A5A5, ready on the first ACCESS cycle -> periph_we = 4'b0010 for 1 cycle, periph_wdata = 0xA5A5_A5A5, stall for 2 cycles, err stays 0.
REQ-042 SHALL cover a read with wait states: read 0x0000_0300, ch3 ready after 3 cycles with data 0x1234_5678 -> periph_re = 4'b1000 for 3 cycles, cpu_rdata = 0x1234_5678 in RESP.
REQ-043 SHALL cover an unmapped access: read 0x0000_1000 -> no strobes, cpu_stall 0, cpu_rdata = 0, err = 1 next cycle; err_clear -> err = 0.
REQ-044 SHALL cover timeout: read ch0 with ready never high -> strobe high for 16 cycles, err = 1, cpu_rdata = 0, FSM back in IDLE after RESP.
REQ-045 SHALL cover reset during ACCESS: reset asserted in the 2nd wait cycle -> strobes and stall low with no clock edge, FSM in IDLE.
REQ-046 SHALL cover simultaneous we and re: both high to ch2 -> write performed only, periph_re stays 0.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared types and default address map for the MMIO router.
package mmio_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  localparam int unsigned DefNCh    = 4;
  localparam int unsigned DefAw     = 32;
  localparam int unsigned DefTimeout = 16;

  // Channel 0 occupies the least-significant AW bits.
  localparam logic [DefNCh*DefAw-1:0] DefBase = {
    32'h0000_0300, 32'h0000_0200, 32'h0000_0100, 32'h0000_0000
  };
  localparam logic [DefNCh*DefAw-1:0] DefMask = {DefNCh{32'hFFFF_FF00}};

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_addr_decoder.sv
// Combinational base/mask address decoder; lowest matching channel wins.
module mmio_addr_decoder
  import mmio_pkg::*;
#(
  parameter int unsigned          N_CH = DefNCh,
  parameter int unsigned          AW   = DefAw,
  parameter logic [N_CH*AW-1:0]   BASE = DefBase,
  parameter logic [N_CH*AW-1:0]   MASK = DefMask,
  parameter int unsigned          IdxW = idx_width(N_CH)
) (
  input  logic [AW-1:0]   addr_i,
  output logic [N_CH-1:0] hit_o,
  output logic [IdxW-1:0] idx_o,
  output logic            mapped_o
);

  always_comb begin
    hit_o = '0;
    for (int i = 0; i < N_CH; i++) begin
      hit_o[i] = (addr_i & MASK[i*AW +: AW]) == BASE[i*AW +: AW];
    end
  end

  // Scan downwards so the lowest hit is the last one written.
  always_comb begin
    idx_o    = '0;
    mapped_o = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (hit_o[i]) begin
        idx_o    = IdxW'(i);
        mapped_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_router.sv
// Routes single CPU MMIO requests to one of N_CH peripherals with wait states,
// timeout abort and a sticky error flag.
module mmio_router
  import mmio_pkg::*;
#(
  parameter int unsigned        N_CH    = DefNCh,
  parameter int unsigned        AW      = DefAw,
  parameter int unsigned        DW      = 32,
  parameter logic [N_CH*AW-1:0] BASE    = DefBase,
  parameter logic [N_CH*AW-1:0] MASK    = DefMask,
  parameter int unsigned        TIMEOUT = DefTimeout
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [DW-1:0]    cpu_wdata,
  input  logic             cpu_we,
  input  logic             cpu_re,
  output logic [DW-1:0]    cpu_rdata,
  output logic             cpu_stall,
  output logic [AW-1:0]    periph_addr,
  output logic [DW-1:0]    periph_wdata,
  output logic [N_CH-1:0]  periph_we,
  output logic [N_CH-1:0]  periph_re,
  input  logic [N_CH*DW-1:0] periph_rdata,
  input  logic [N_CH-1:0]  periph_ready,
  output logic             err,
  input  logic             err_clear
);

  localparam int unsigned IdxW = idx_width(N_CH);
  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            op_we_q, op_we_d;
  logic [IdxW-1:0] ch_q, ch_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [N_CH-1:0] dec_hit;
  logic [IdxW-1:0] dec_idx;
  logic            dec_mapped;
  logic            req;
  logic            stall;
  logic            err_set;
  logic            sel_ready;
  logic [DW-1:0]   sel_rdata;
  logic [N_CH-1:0] ch_onehot;

  mmio_addr_decoder #(
    .N_CH (N_CH),
    .AW   (AW),
    .BASE (BASE),
    .MASK (MASK),
    .IdxW (IdxW)
  ) u_decoder (
    .addr_i   (cpu_addr),
    .hit_o    (dec_hit),
    .idx_o    (dec_idx),
    .mapped_o (dec_mapped)
  );

  // A write takes precedence when both strobes are raised.
  assign req       = cpu_we | cpu_re;
  assign sel_ready = periph_ready[ch_q];
  assign sel_rdata = periph_rdata[ch_q*DW +: DW];
  assign ch_onehot = N_CH'(1) << ch_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_we_d = op_we_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_set = 1'b0;
    stall   = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (req && dec_mapped) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          op_we_d = cpu_we;
          ch_d    = dec_idx;
          stall   = 1'b1;
          state_d = StAccess;
        end else if (req && ~|dec_hit) begin
          err_set = 1'b1;
          if (!cpu_we) rdata_d = '0;
        end
      end
      StAccess: begin
        stall = 1'b1;
        cnt_d = cnt_q + CntW'(1);
        if (sel_ready) begin
          if (!op_we_q) rdata_d = sel_rdata;
          state_d = StResp;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          err_set = 1'b1;
          if (!op_we_q) rdata_d = '0;
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (err_set)        err_d = 1'b1;
    else if (err_clear) err_d = 1'b0;
    else                err_d = err_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      op_we_q <= 1'b0;
      ch_q    <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_we_q <= op_we_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Stall is combinational in IDLE, so gate it so reset forces it low at once.
  assign cpu_stall    = stall & ~reset;
  assign periph_we    = (state_q == StAccess && op_we_q)  ? ch_onehot : '0;
  assign periph_re    = (state_q == StAccess && !op_we_q) ? ch_onehot : '0;
  assign periph_addr  = addr_q;
  assign periph_wdata = wdata_q;
  assign cpu_rdata    = rdata_q;
  assign err          = err_q;

endmodule
